// File: rtl/spi_target_emu.sv
// spi_target_emu: chip-side SPI target emulator for FPGA-in-loop bring-up.
// Decodes config/waveform frames and shifts a status response out on miso.
module spi_target_emu #(
   parameter int DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        spi_clk_out,
   input  logic        cs_b,
   input  logic        mosi,
   input  logic        spi_sel,
   output logic        miso,
   output logic        cfg_wr,
   output logic [3:0]  cfg_addr,
   output logic [31:0] cfg_data,
   output logic        wav_valid,
   output logic [31:0] wav_data,
   output logic        frame_err,
   output logic [15:0] frame_count
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d;
   logic [1:0]    cs_sync_q, cs_sync_d;
   logic [1:0]    mosi_sync_q, mosi_sync_d;
   logic [1:0]    sel_sync_q, sel_sync_d;
   logic          type_q, type_d;
   logic [63:0]   tx_q, tx_d;
   logic [63:0]   rx_q, rx_d;
   logic [6:0]    bits_q, bits_d;
   logic          miso_q, miso_d;
   logic          cfg_wr_q, cfg_wr_d;
   logic [3:0]    cfg_addr_q, cfg_addr_d;
   logic [31:0]   cfg_data_q, cfg_data_d;
   logic          wav_valid_q, wav_valid_d;
   logic [31:0]   wav_data_q, wav_data_d;
   logic          frame_err_q, frame_err_d;
   logic [15:0]   frame_count_q, frame_count_d;
   logic [3:0]    rd_addr_q, rd_addr_d;
   logic [31:0]   regs_q [16];
   logic [31:0]   regs_d [16];

   logic cs_s, mosi_s, sel_s, rise, fall;
   logic unused_bits;

   assign cs_s   = cs_sync_q[1];
   assign mosi_s = mosi_sync_q[1];
   assign sel_s  = sel_sync_q[1];
   assign rise   = (div_q == DIV_MAX) && !sclk_q;
   assign fall   = (div_q == DIV_MAX) && sclk_q;
   assign unused_bits = ^{rx_q[62:60], rx_q[55:32], tx_q[63]};

   always_comb begin
      state_d       = state_q;
      div_d         = div_q + DIV_ONE;
      sclk_d        = sclk_q;
      cs_sync_d     = {cs_sync_q[0], cs_b};
      mosi_sync_d   = {mosi_sync_q[0], mosi};
      sel_sync_d    = {sel_sync_q[0], spi_sel};
      type_d        = type_q;
      tx_d          = tx_q;
      rx_d          = rx_q;
      bits_d        = bits_q;
      miso_d        = miso_q;
      cfg_wr_d      = 1'b0;
      cfg_addr_d    = cfg_addr_q;
      cfg_data_d    = cfg_data_q;
      wav_valid_d   = 1'b0;
      wav_data_d    = wav_data_q;
      frame_err_d   = 1'b0;
      frame_count_d = frame_count_q;
      rd_addr_d     = rd_addr_q;
      regs_d        = regs_q;

      if (div_q == DIV_MAX) begin
         div_d  = '0;
         sclk_d = !sclk_q;
      end

      unique case (state_q)
         IDLE: begin
            if (!cs_s) state_d = LOAD;
         end
         LOAD: begin
            type_d  = sel_s;
            tx_d    = {8'hA5, 4'h0, rd_addr_q, frame_count_q,
                       regs_q[rd_addr_q]};
            bits_d  = '0;
            miso_d  = tx_d[63];
            state_d = SHIFT;
         end
         SHIFT: begin
            if (cs_s) begin
               state_d = DONE;
               // Commit decisions land in the DONE cycle via the registers
               if (!type_q && bits_q == 7'd64) begin
                  frame_count_d = frame_count_q + 16'd1;
                  if (rx_q[63]) begin
                     regs_d[rx_q[59:56]] = rx_q[31:0];
                     cfg_addr_d = rx_q[59:56];
                     cfg_data_d = rx_q[31:0];
                     cfg_wr_d   = 1'b1;
                  end else begin
                     rd_addr_d = rx_q[59:56];
                  end
               end else if (type_q && bits_q == 7'd32) begin
                  frame_count_d = frame_count_q + 16'd1;
                  wav_data_d    = rx_q[31:0];
                  wav_valid_d   = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (rise) begin
                  rx_d = {rx_q[62:0], mosi_s};
                  if (bits_q != 7'd127) bits_d = bits_q + 7'd1;
               end
               if (fall) begin
                  tx_d   = {tx_q[62:0], 1'b0};
                  miso_d = tx_q[62];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         div_q         <= '0;
         sclk_q        <= 1'b0;
         cs_sync_q     <= 2'b11;
         mosi_sync_q   <= 2'b00;
         sel_sync_q    <= 2'b00;
         type_q        <= 1'b0;
         tx_q          <= '0;
         rx_q          <= '0;
         bits_q        <= '0;
         miso_q        <= 1'b0;
         cfg_wr_q      <= 1'b0;
         cfg_addr_q    <= '0;
         cfg_data_q    <= '0;
         wav_valid_q   <= 1'b0;
         wav_data_q    <= '0;
         frame_err_q   <= 1'b0;
         frame_count_q <= '0;
         rd_addr_q     <= '0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         sclk_q        <= sclk_d;
         cs_sync_q     <= cs_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         sel_sync_q    <= sel_sync_d;
         type_q        <= type_d;
         tx_q          <= tx_d;
         rx_q          <= rx_d;
         bits_q        <= bits_d;
         miso_q        <= miso_d;
         cfg_wr_q      <= cfg_wr_d;
         cfg_addr_q    <= cfg_addr_d;
         cfg_data_q    <= cfg_data_d;
         wav_valid_q   <= wav_valid_d;
         wav_data_q    <= wav_data_d;
         frame_err_q   <= frame_err_d;
         frame_count_q <= frame_count_d;
         rd_addr_q     <= rd_addr_d;
         for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign spi_clk_out = sclk_q;
   assign miso        = miso_q;
   assign cfg_wr      = cfg_wr_q;
   assign cfg_addr    = cfg_addr_q;
   assign cfg_data    = cfg_data_q;
   assign wav_valid   = wav_valid_q;
   assign wav_data    = wav_data_q;
   assign frame_err   = frame_err_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_target_emu.sv
// tb_spi_target_emu: directed bench for the SPI target emulator.
// Plays the SPI controller: launches mosi on falling edges, samples miso on rising.
module tb_spi_target_emu;
   logic        clk = 1'b0;
   logic        rst;
   logic        spi_clk_out;
   logic        cs_b;
   logic        mosi;
   logic        spi_sel;
   logic        miso;
   logic        cfg_wr;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        wav_valid;
   logic [31:0] wav_data;
   logic        frame_err;
   logic [15:0] frame_count;

   int tests_run = 0;
   int tests_failed = 0;
   int n_cfg = 0;
   int n_wav = 0;
   int n_err = 0;

   spi_target_emu #(.DIV(4)) dut (
      .clk(clk),
      .rst(rst),
      .spi_clk_out(spi_clk_out),
      .cs_b(cs_b),
      .mosi(mosi),
      .spi_sel(spi_sel),
      .miso(miso),
      .cfg_wr(cfg_wr),
      .cfg_addr(cfg_addr),
      .cfg_data(cfg_data),
      .wav_valid(wav_valid),
      .wav_data(wav_data),
      .frame_err(frame_err),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Count pulse-high cycles so a stretched pulse also shows up
   always @(negedge clk) begin
      if (cfg_wr) n_cfg++;
      if (wav_valid) n_wav++;
      if (frame_err) n_err++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic sel, input int nbits,
                             input logic [63:0] data, input int abort_at,
                             output logic [63:0] rx);
      rx = '0;
      @(posedge spi_clk_out);
      @(negedge clk);
      spi_sel = sel;
      cs_b = 1'b0;
      mosi = data[nbits-1];
      for (int i = nbits - 1; i >= 0; i--) begin
         @(posedge spi_clk_out);
         @(negedge clk);
         rx = {rx[62:0], miso};
         spi_sel = ~sel;
         if (abort_at != 0 && (nbits - i) == abort_at) begin
            rst = 1'b1;
            return;
         end
         @(negedge spi_clk_out);
         @(negedge clk);
         if (i > 0) mosi = data[i-1];
      end
      cs_b = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      logic exp_clk;
      rst = 1'b1;
      cs_b = 1'b1;
      mosi = 1'b0;
      spi_sel = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({spi_clk_out, miso, cfg_wr, wav_valid, frame_err} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_bits: got %b required 00000",
                  {spi_clk_out, miso, cfg_wr, wav_valid, frame_err});
      end
      tests_run++;
      if ({cfg_addr, cfg_data, wav_data, frame_count} !== 84'h0) begin
         tests_failed++;
         $display("FAIL reset_words: got %h required 0",
                  {cfg_addr, cfg_data, wav_data, frame_count});
      end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_clk = (k >= 4 && k <= 7);
         tests_run++;
         if (spi_clk_out !== exp_clk) begin
            tests_failed++;
            $display("FAIL clk_div cycle %0d: got %b required %b",
                     k, spi_clk_out, exp_clk);
         end
      end
   endtask

   task automatic test_cfg_write();
      logic [63:0] rx;
      int c0 = n_cfg;
      int e0 = n_err;
      send_frame(1'b0, 64, {1'b1, 3'b0, 4'h5, 24'h0, 32'hDEADBEEF}, 0, rx);
      tests_run++;
      if (n_cfg - c0 != 1) begin
         tests_failed++;
         $display("FAIL wr_pulse: got %0d required 1", n_cfg - c0);
      end
      tests_run++;
      if (n_err != e0) begin
         tests_failed++;
         $display("FAIL wr_no_err: got %0d required 0", n_err - e0);
      end
      tests_run++;
      if (cfg_addr !== 4'h5 || cfg_data !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL wr_addr_data: got %h/%h required 5/deadbeef",
                  cfg_addr, cfg_data);
      end
      tests_run++;
      if (frame_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL wr_count: got %0d required 1", frame_count);
      end
      tests_run++;
      if (rx !== 64'hA500_0000_0000_0000) begin
         tests_failed++;
         $display("FAIL wr_miso: got %h required a500000000000000", rx);
      end
   endtask

   task automatic test_read_back();
      logic [63:0] rx;
      int c0 = n_cfg;
      send_frame(1'b0, 64, {1'b0, 3'b0, 4'h5, 56'h0}, 0, rx);
      tests_run++;
      if (n_cfg != c0 || cfg_addr !== 4'h5) begin
         tests_failed++;
         $display("FAIL rd_no_write: got %0d pulses addr %h required 0/5",
                  n_cfg - c0, cfg_addr);
      end
      tests_run++;
      if (frame_count !== 16'd2) begin
         tests_failed++;
         $display("FAIL rd_count: got %0d required 2", frame_count);
      end
      tests_run++;
      if (rx !== 64'hA500_0001_0000_0000) begin
         tests_failed++;
         $display("FAIL rd_miso: got %h required a500000100000000", rx);
      end
      send_frame(1'b0, 64, {1'b1, 3'b0, 4'h3, 24'h0, 32'h12345678}, 0, rx);
      tests_run++;
      if (rx !== 64'hA505_0002_DEADBEEF) begin
         tests_failed++;
         $display("FAIL readback_miso: got %h required a5050002deadbeef", rx);
      end
      tests_run++;
      if (cfg_addr !== 4'h3 || cfg_data !== 32'h12345678
          || frame_count !== 16'd3) begin
         tests_failed++;
         $display("FAIL wr2: got %h/%h/%0d required 3/12345678/3",
                  cfg_addr, cfg_data, frame_count);
      end
   endtask

   task automatic test_waveform();
      logic [63:0] rx;
      int c0 = n_cfg;
      int w0 = n_wav;
      send_frame(1'b1, 32, 64'h0000_0000_0001_2345, 0, rx);
      tests_run++;
      if (n_wav - w0 != 1 || n_cfg != c0) begin
         tests_failed++;
         $display("FAIL wav_pulse: got wav %0d cfg %0d required 1/0",
                  n_wav - w0, n_cfg - c0);
      end
      tests_run++;
      if (wav_data !== 32'h0001_2345 || frame_count !== 16'd4) begin
         tests_failed++;
         $display("FAIL wav_data: got %h/%0d required 00012345/4",
                  wav_data, frame_count);
      end
      tests_run++;
      if (rx[31:0] !== 32'hA505_0003) begin
         tests_failed++;
         $display("FAIL wav_miso: got %h required a5050003", rx[31:0]);
      end
   endtask

   task automatic test_bad_length();
      logic [63:0] rx;
      int c0 = n_cfg;
      int w0 = n_wav;
      int e0 = n_err;
      send_frame(1'b0, 63, 64'hFFFF_FFFF_FFFF_FFFF, 0, rx);
      tests_run++;
      if (n_err - e0 != 1 || n_cfg != c0) begin
         tests_failed++;
         $display("FAIL bad63: got err %0d cfg %0d required 1/0",
                  n_err - e0, n_cfg - c0);
      end
      tests_run++;
      if (frame_count !== 16'd4 || cfg_addr !== 4'h3) begin
         tests_failed++;
         $display("FAIL bad63_state: got %0d/%h required 4/3",
                  frame_count, cfg_addr);
      end
      e0 = n_err;
      send_frame(1'b1, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0, rx);
      tests_run++;
      if (n_err - e0 != 1 || n_wav != w0) begin
         tests_failed++;
         $display("FAIL bad33: got err %0d wav %0d required 1/0",
                  n_err - e0, n_wav - w0);
      end
      tests_run++;
      if (wav_data !== 32'h0001_2345 || frame_count !== 16'd4) begin
         tests_failed++;
         $display("FAIL bad33_state: got %h/%0d required 00012345/4",
                  wav_data, frame_count);
      end
      send_frame(1'b0, 64, {1'b0, 3'b0, 4'hF, 56'h0}, 0, rx);
      tests_run++;
      if (rx !== 64'hA505_0004_DEADBEEF) begin
         tests_failed++;
         $display("FAIL bad_rd1: got %h required a5050004deadbeef", rx);
      end
      send_frame(1'b0, 64, {1'b0, 3'b0, 4'hF, 56'h0}, 0, rx);
      tests_run++;
      if (rx !== 64'hA50F_0005_0000_0000) begin
         tests_failed++;
         $display("FAIL bad_rd2: got %h required a50f000500000000", rx);
      end
   endtask

   task automatic test_abort();
      logic [63:0] rx;
      int c0 = n_cfg;
      int w0 = n_wav;
      int e0 = n_err;
      send_frame(1'b0, 64, {1'b1, 3'b0, 4'h7, 24'h0, 32'hCAFEF00D}, 20, rx);
      cs_b = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({spi_clk_out, miso, cfg_wr, wav_valid, frame_err,
           cfg_addr, cfg_data, wav_data, frame_count} !== 89'h0) begin
         tests_failed++;
         $display("FAIL abort_outputs: got %h required 0",
                  {spi_clk_out, miso, cfg_wr, wav_valid, frame_err,
                   cfg_addr, cfg_data, wav_data, frame_count});
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      send_frame(1'b1, 32, 64'h0000_0000_ABCD_0123, 0, rx);
      tests_run++;
      if (n_cfg != c0 || n_err != e0 || n_wav - w0 != 1) begin
         tests_failed++;
         $display("FAIL abort_pulses: got cfg %0d err %0d wav %0d required 0/0/1",
                  n_cfg - c0, n_err - e0, n_wav - w0);
      end
      tests_run++;
      if (wav_data !== 32'hABCD_0123 || frame_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL abort_next: got %h/%0d required abcd0123/1",
                  wav_data, frame_count);
      end
      tests_run++;
      if (rx[31:0] !== 32'hA500_0000) begin
         tests_failed++;
         $display("FAIL abort_miso: got %h required a5000000", rx[31:0]);
      end
   endtask

   task automatic test_wrap();
      logic [63:0] rx;
      int c0 = n_cfg;
      @(negedge clk);
      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_q;
      @(negedge clk);
      tests_run++;
      if (frame_count !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL wrap_preset: got %h required ffff", frame_count);
      end
      send_frame(1'b0, 64, {1'b1, 3'b0, 4'h2, 24'h0, 32'h0000_0001}, 0, rx);
      tests_run++;
      if (frame_count !== 16'h0000 || n_cfg - c0 != 1) begin
         tests_failed++;
         $display("FAIL wrap_count: got %h pulses %0d required 0000/1",
                  frame_count, n_cfg - c0);
      end
      tests_run++;
      if (rx !== 64'hA500_FFFF_0000_0000) begin
         tests_failed++;
         $display("FAIL wrap_miso: got %h required a500ffff00000000", rx);
      end
   endtask

   initial begin
      test_reset();
      test_cfg_write();
      test_read_back();
      test_waveform();
      test_bad_length();
      test_abort();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
